term_cursor_writer: RTL

TERM_CURSOR_WRITER -- requirements
Module: term_cursor_writer

---
 rtl/term_pkg.sv | 29 ++
 rtl/term_cursor_writer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/term_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : term_pkg
//  Description : Shared definitions for the terminal cursor writer: control
//                byte codes, FSM state encoding and a printable-byte helper.
//  Revision    : 1.0  initial release
// ============================================================================
package term_pkg;

    // Control bytes interpreted by the writer
    localparam logic [7:0] c_ch_bs  = 8'h08;
    localparam logic [7:0] c_ch_tab = 8'h09;
    localparam logic [7:0] c_ch_lf  = 8'h0A;
    localparam logic [7:0] c_ch_ff  = 8'h0C;
    localparam logic [7:0] c_ch_cr  = 8'h0D;

    // FSM state encoding
    localparam logic [1:0] c_st_idle       = 2'd0;
    localparam logic [1:0] c_st_write      = 2'd1;
    localparam logic [1:0] c_st_clear_line = 2'd2;
    localparam logic [1:0] c_st_clear_all  = 2'd3;

    // Printable ASCII range 0x20..0x7E
    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

endpackage
`default_nettype wire

// File: rtl/term_cursor_writer.sv
`default_nettype none
// ============================================================================
//  Module      : term_cursor_writer
//  Description : Byte-stream terminal writer. Accepts characters over a
//                valid/ready handshake, writes printable codes into a
//                character RAM at the cursor, and handles CR, LF, BS, TAB and
//                FF. Scrolling is done by rotating scroll_row and clearing the
//                new bottom line rather than moving RAM contents.
//  Ports       : clk100      - sole clock, rising edge
//                rst         - synchronous active-high reset
//                rx_data     - incoming byte
//                rx_valid    - rx_data valid, held until accepted
//                rx_ready    - byte accepted this cycle if rx_valid is high
//                wr_en       - one-cycle character RAM write strobe
//                wr_addr     - physical cell address, phys_row*COLS+col
//                wr_data     - character code to write
//                scroll_row  - physical row shown at the top of the display
//  Revision    : 1.0  initial release
// ============================================================================
module term_cursor_writer
    import term_pkg::*;
#(
    parameter int         COLS      = 80,
    parameter int         ROWS      = 25,
    parameter int         TAB_W     = 8,
    parameter logic [7:0] FILL_CHAR = 8'h20,
    localparam int        ADDR_W    = $clog2(COLS*ROWS),
    localparam int        ROW_W     = $clog2(ROWS)
) (
    input  logic              clk100,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [ROW_W-1:0]  scroll_row
);

    localparam int c_col_w = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [c_col_w-1:0] c_col_last  = c_col_w'(COLS - 1);
    localparam logic [ROW_W-1:0]   c_row_last  = ROW_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0]  c_cols      = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0]  c_line_last = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0]  c_cell_last = ADDR_W'(COLS*ROWS - 1);

    logic [1:0]         r_state;
    logic [c_col_w-1:0] r_col;
    logic [ROW_W-1:0]   r_row;
    logic [ROW_W-1:0]   r_scroll;
    logic [ROW_W-1:0]   r_phys_row;   // (r_row + r_scroll) mod ROWS, kept incrementally
    logic [ADDR_W-1:0]  r_base;       // r_phys_row * COLS, kept incrementally
    logic [ADDR_W-1:0]  r_clr_cnt;
    logic               r_wr_en;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [7:0]         r_wr_data;

    logic [ROW_W-1:0]   w_phys_next;
    logic [ADDR_W-1:0]  w_base_next;
    logic [ROW_W-1:0]   w_scroll_next;
    logic [c_col_w-1:0] w_tab_col;
    int                 w_tab_sum;
    logic               w_accept;

    // Ready only when idle and not still presenting the final write of a
    // sequence, so no byte is taken while the RAM port is busy.
    assign rx_ready = (r_state == c_st_idle) && !r_wr_en && !rst;
    assign w_accept = rx_valid && rx_ready;

    // A line feed always moves the physical cursor row down by one: either
    // the logical row grows, or the scroll offset grows with the row fixed.
    always_comb begin
        w_phys_next   = (r_phys_row == c_row_last) ? '0 : r_phys_row + ROW_W'(1);
        w_base_next   = (r_phys_row == c_row_last) ? '0 : r_base + c_cols;
        w_scroll_next = (r_scroll == c_row_last)   ? '0 : r_scroll + ROW_W'(1);
    end

    // Next tab stop strictly beyond the current column, clamped to the edge.
    always_comb begin
        w_tab_sum = (int'(r_col) | (TAB_W - 1)) + 1;
        if (w_tab_sum > COLS - 1) begin
            w_tab_sum = COLS - 1;
        end
        w_tab_col = c_col_w'(w_tab_sum);
    end

    always_ff @(posedge clk100) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_col      <= '0;
            r_row      <= '0;
            r_scroll   <= '0;
            r_phys_row <= '0;
            r_base     <= '0;
            r_clr_cnt  <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        if (is_printable(rx_data)) begin
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= r_base + ADDR_W'(r_col);
                            r_wr_data <= rx_data;
                            r_state   <= c_st_write;
                        end else begin
                            case (rx_data)
                                c_ch_cr: r_col <= '0;
                                c_ch_bs: begin
                                    if (r_col != '0) begin
                                        r_col <= r_col - c_col_w'(1);
                                    end
                                end
                                c_ch_tab: r_col <= w_tab_col;
                                c_ch_lf: begin
                                    r_phys_row <= w_phys_next;
                                    r_base     <= w_base_next;
                                    if (r_row == c_row_last) begin
                                        r_scroll  <= w_scroll_next;
                                        r_clr_cnt <= '0;
                                        r_state   <= c_st_clear_line;
                                    end else begin
                                        r_row <= r_row + ROW_W'(1);
                                    end
                                end
                                c_ch_ff: begin
                                    r_clr_cnt <= '0;
                                    r_state   <= c_st_clear_all;
                                end
                                default: ;
                            endcase
                        end
                    end
                end

                // Write strobe is on the bus this cycle; advance the cursor.
                c_st_write: begin
                    r_state <= c_st_idle;
                    if (r_col == c_col_last) begin
                        r_col      <= '0;
                        r_phys_row <= w_phys_next;
                        r_base     <= w_base_next;
                        if (r_row == c_row_last) begin
                            r_scroll  <= w_scroll_next;
                            r_clr_cnt <= '0;
                            r_state   <= c_st_clear_line;
                        end else begin
                            r_row <= r_row + ROW_W'(1);
                        end
                    end else begin
                        r_col <= r_col + c_col_w'(1);
                    end
                end

                // r_base already points at the new bottom row.
                c_st_clear_line: begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= r_base + r_clr_cnt;
                    r_wr_data <= FILL_CHAR;
                    if (r_clr_cnt == c_line_last) begin
                        r_state <= c_st_idle;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
                    end
                end

                c_st_clear_all: begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= r_clr_cnt;
                    r_wr_data <= FILL_CHAR;
                    if (r_clr_cnt == c_cell_last) begin
                        r_state    <= c_st_idle;
                        r_scroll   <= '0;
                        r_col      <= '0;
                        r_row      <= '0;
                        r_phys_row <= '0;
                        r_base     <= '0;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
                    end
                end

                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign scroll_row = r_scroll;

endmodule
`default_nettype wire
